// File: rtl/ecg_clk_pkg.sv
// rtl/ecg_clk_pkg.sv - shared state encoding for the ECG clock-enable sequencer
package ecg_clk_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer with toggle detect, masked while the pipeline primes
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic       sync1;
  logic       sync2;
  logic       sync2_d;
  logic [1:0] mask_cnt;
  logic       armed;

  assign armed = (mask_cnt == 2'd2);
  assign pulse = armed & (sync2 ^ sync2_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync2_d  <= 1'b0;
      mask_cnt <= 2'd0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // While masked, sync2_d tracks what sync2 is about to become, so the
      // level present at reset release never appears as a toggle.
      sync2_d <= armed ? sync2 : sync1;
      if (!armed) mask_cnt <= mask_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/clk_en_seq.sv
// rtl/clk_en_seq.sv - run/stop sequencer producing a divided clock-enable strobe
module clk_en_seq
  import ecg_clk_pkg::*;
#(
  parameter int START_DLY = 3,
  parameter int STOP_DLY  = 4,
  parameter int DIV       = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       switch,
  output logic       clk_en,
  output logic       running,
  output logic       start_ack,
  output logic       stop_ack,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DLY - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_DLY - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);

  logic             sw_edge;
  state_e           state_q, state_n;
  logic [CNT_W-1:0] dly_cnt, dly_n;
  logic [CNT_W-1:0] div_cnt, div_n, div_wrap;
  logic             pending, pending_n;
  logic             start_ack_n, stop_ack_n;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (switch),
    .pulse (sw_edge)
  );

  assign div_wrap = (div_cnt == DIV_LAST) ? '0 : div_cnt + CNT_W'(1);
  assign state    = state_q;

  always_comb begin
    state_n     = state_q;
    dly_n       = dly_cnt;
    div_n       = '0;
    pending_n   = pending;
    start_ack_n = 1'b0;
    stop_ack_n  = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (sw_edge) begin
          state_n = ST_WARMUP;
          dly_n   = '0;
        end
      end
      ST_WARMUP: begin
        // A fresh toggle restarts the warm-up even on its final cycle.
        if (sw_edge) begin
          dly_n = '0;
        end else if (dly_cnt == START_LAST) begin
          state_n     = ST_RUN;
          start_ack_n = 1'b1;
          dly_n       = '0;
        end else begin
          dly_n = dly_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        div_n = div_wrap;
        if (sw_edge) begin
          state_n = ST_DRAIN;
          dly_n   = '0;
        end
      end
      ST_DRAIN: begin
        div_n = div_wrap;
        if (dly_cnt == STOP_LAST) begin
          state_n    = (pending || sw_edge) ? ST_WARMUP : ST_OFF;
          stop_ack_n = 1'b1;
          pending_n  = 1'b0;
          dly_n      = '0;
          div_n      = '0;
        end else begin
          dly_n = dly_cnt + CNT_W'(1);
          if (sw_edge) pending_n = 1'b1;
        end
      end
      default: state_n = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      dly_cnt   <= '0;
      div_cnt   <= '0;
      pending   <= 1'b0;
      clk_en    <= 1'b0;
      running   <= 1'b0;
      start_ack <= 1'b0;
      stop_ack  <= 1'b0;
    end else begin
      state_q   <= state_n;
      dly_cnt   <= dly_n;
      div_cnt   <= div_n;
      pending   <= pending_n;
      // Outputs are derived from next state so they align with the state they describe.
      running   <= is_active(state_n);
      clk_en    <= is_active(state_n) && (div_n == '0);
      start_ack <= start_ack_n;
      stop_ack  <= stop_ack_n;
    end
  end

endmodule
